// File: rtl/mesh_ni_pkg.sv
// Shared definitions for the mesh network interface.
//   - mesh geometry defaults and the node/coordinate field widths
//   - packet_t, mirroring the router's shared packet layout
//   - node_id(), dest_x(), dest_y() helpers
package mesh_ni_pkg;

    localparam int unsigned MESH_X_NODES = 4;
    localparam int unsigned MESH_Y_NODES = 4;
    localparam int unsigned NODE_W       = $clog2(MESH_X_NODES * MESH_Y_NODES);
    localparam int unsigned COORD_W      = NODE_W / 2;
    localparam int unsigned TS_WIDTH_DEF = 16;
    localparam int unsigned PAYLOAD_W    = 32;

    typedef struct packed {
        logic [NODE_W-1:0]       dest;      // low half X, high half Y
        logic [NODE_W-1:0]       source;
        logic [TS_WIDTH_DEF-1:0] timestamp;
        logic [PAYLOAD_W-1:0]    payload;
    } packet_t;

    function automatic logic [NODE_W-1:0] node_id(int unsigned x, int unsigned y,
                                                  int unsigned x_nodes);
        return NODE_W'(y * x_nodes + x);
    endfunction

    function automatic logic [COORD_W-1:0] dest_x(logic [NODE_W-1:0] dest);
        return dest[COORD_W-1:0];
    endfunction

    function automatic logic [COORD_W-1:0] dest_y(logic [NODE_W-1:0] dest);
        return dest[NODE_W-1:COORD_W];
    endfunction

endpackage

// File: rtl/mesh_network_interface_if.sv
// Bundle of all NI data-path signals: core injection, router port 0 in/out,
// core ejection, counters and the sticky misroute flag.
//   slave  : the network interface itself
//   master : the environment (core source/sink and router port 0)
// With MESH_NI_LATENCY_STATS_EN defined, o_lat_sum / o_lat_max are added.
interface mesh_network_interface_if
    import mesh_ni_pkg::*;
#(
    parameter int unsigned TS_WIDTH = TS_WIDTH_DEF
);
    packet_t       i_pkt;
    logic          i_pkt_val;
    logic          o_pkt_en;
    packet_t       o_net_data;
    logic          o_net_data_val;
    logic          i_net_en;
    packet_t       i_net_data;
    logic          i_net_data_val;
    logic          o_net_en;
    packet_t       o_rx_pkt;
    logic          o_rx_val;
    logic          i_rx_en;
    logic [31:0]   o_tx_count;
    logic [31:0]   o_rx_count;
    logic          o_misroute;
`ifdef MESH_NI_LATENCY_STATS_EN
    logic [47:0]         o_lat_sum;
    logic [TS_WIDTH-1:0] o_lat_max;
`endif

    modport slave (
        input  i_pkt, i_pkt_val, i_net_en, i_net_data, i_net_data_val, i_rx_en,
        output o_pkt_en, o_net_data, o_net_data_val, o_net_en, o_rx_pkt, o_rx_val,
        output o_tx_count, o_rx_count, o_misroute
`ifdef MESH_NI_LATENCY_STATS_EN
        , output o_lat_sum, o_lat_max
`endif
    );

    modport master (
        output i_pkt, i_pkt_val, i_net_en, i_net_data, i_net_data_val, i_rx_en,
        input  o_pkt_en, o_net_data, o_net_data_val, o_net_en, o_rx_pkt, o_rx_val,
        input  o_tx_count, o_rx_count, o_misroute
`ifdef MESH_NI_LATENCY_STATS_EN
        , input o_lat_sum, o_lat_max
`endif
    );

endinterface

// File: rtl/mesh_ni_tx_fifo.sv
// Injection packet FIFO. Power-of-2 depth, pointers wrap naturally.
//   clk, reset_n : clock, synchronous active-low reset
//   push/push_pkt: write (ignored while full)
//   pop          : read  (ignored while empty)
//   head_pkt     : oldest entry (undefined contents while empty)
//   full, empty  : occupancy flags
module mesh_ni_tx_fifo
    import mesh_ni_pkg::*;
#(
    parameter int unsigned Depth = 4
) (
    input  logic    clk,
    input  logic    reset_n,
    input  logic    push,
    input  packet_t push_pkt,
    input  logic    pop,
    output packet_t head_pkt,
    output logic    full,
    output logic    empty
);
    localparam int unsigned PTR_W = $clog2(Depth);
    localparam int unsigned CNT_W = PTR_W + 1;

    packet_t          mem [Depth];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign full     = (count_q == CNT_W'(Depth));
    assign empty    = (count_q == '0);
    assign head_pkt = mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset; head is masked by the top while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= push_pkt;
    end

endmodule

// File: rtl/mesh_network_interface.sv
// Core-side network interface for one mesh node (router port 0).
//   clk, reset_n : clock, synchronous active-low reset
//   ni (slave)   : injection from core, router in/out, ejection to core,
//                  tx/rx counters, sticky misroute flag
// Injection stamps source=NODE_ID and the current timestamp, then queues in
// mesh_ni_tx_fifo. Ejection uses a one-entry register; packets whose dest
// is not this node are dropped and flag o_misroute.
// Optional macro MESH_NI_LATENCY_STATS_EN adds o_lat_sum / o_lat_max.
module mesh_network_interface
    import mesh_ni_pkg::*;
#(
    parameter int unsigned X_NODES  = 4,
    parameter int unsigned Y_NODES  = 4,
    parameter int unsigned X_LOC    = 0,
    parameter int unsigned Y_LOC    = 0,
    parameter int unsigned TX_DEPTH = 4,
    parameter int unsigned TS_WIDTH = TS_WIDTH_DEF
) (
    input logic                   clk,
    input logic                   reset_n,
    mesh_network_interface_if.slave ni
);
    // Coordinates outside the mesh wrap rather than alias to a foreign node.
    localparam int unsigned MY_X = X_LOC % X_NODES;
    localparam int unsigned MY_Y = Y_LOC % Y_NODES;
    localparam logic [NODE_W-1:0] NODE_ID = node_id(MY_X, MY_Y, X_NODES);

    logic [TS_WIDTH-1:0] ts_q;
    packet_t             tx_in, tx_head;
    logic                tx_full, tx_empty, tx_push, tx_pop;
    logic                rx_full_q, misroute_q;
    packet_t             rx_pkt_q;
    logic [31:0]         tx_count_q, rx_count_q;
    logic                net_en, net_xfer, rx_drain, dest_ok;

    always_comb begin
        tx_in           = ni.i_pkt;
        tx_in.source    = NODE_ID;
        tx_in.timestamp = TS_WIDTH_DEF'(ts_q);
    end

    // No bypass: a full FIFO refuses input even when it pops this cycle.
    assign tx_push = ni.i_pkt_val && !tx_full;
    assign tx_pop  = !tx_empty && ni.i_net_en;

    mesh_ni_tx_fifo #(
        .Depth (TX_DEPTH)
    ) u_tx_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (tx_push),
        .push_pkt (tx_in),
        .pop      (tx_pop),
        .head_pkt (tx_head),
        .full     (tx_full),
        .empty    (tx_empty)
    );

    assign net_en   = !rx_full_q || ni.i_rx_en;
    assign net_xfer = ni.i_net_data_val && net_en;
    assign rx_drain = rx_full_q && ni.i_rx_en;
    assign dest_ok  = (dest_x(ni.i_net_data.dest) == COORD_W'(MY_X)) &&
                      (dest_y(ni.i_net_data.dest) == COORD_W'(MY_Y));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ts_q       <= '0;
            rx_full_q  <= 1'b0;
            rx_pkt_q   <= '0;
            tx_count_q <= '0;
            rx_count_q <= '0;
            misroute_q <= 1'b0;
        end else begin
            ts_q <= ts_q + TS_WIDTH'(1);
            if (tx_pop && (tx_count_q != '1))   tx_count_q <= tx_count_q + 32'd1;
            if (rx_drain && (rx_count_q != '1)) rx_count_q <= rx_count_q + 32'd1;
            // A load wins over a drain, so drain+load keeps the entry full.
            if (net_xfer && dest_ok) begin
                rx_full_q <= 1'b1;
                rx_pkt_q  <= ni.i_net_data;
            end else if (rx_drain) begin
                rx_full_q <= 1'b0;
            end
            if (net_xfer && !dest_ok) misroute_q <= 1'b1;
        end
    end

`ifdef MESH_NI_LATENCY_STATS_EN
    logic [TS_WIDTH-1:0] latency, lat_max_q;
    logic [47:0]         lat_sum_q;
    logic [48:0]         lat_sum_next;

    // Modular subtraction handles timestamp wrap.
    assign latency      = ts_q - TS_WIDTH'(rx_pkt_q.timestamp);
    assign lat_sum_next = {1'b0, lat_sum_q} + 49'(latency);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lat_sum_q <= '0;
            lat_max_q <= '0;
        end else if (rx_drain) begin
            lat_sum_q <= lat_sum_next[48] ? '1 : lat_sum_next[47:0];
            if (latency > lat_max_q) lat_max_q <= latency;
        end
    end

    assign ni.o_lat_sum = lat_sum_q;
    assign ni.o_lat_max = lat_max_q;
`endif

    assign ni.o_pkt_en       = !tx_full;
    assign ni.o_net_data     = tx_empty ? '0 : tx_head;
    assign ni.o_net_data_val = !tx_empty;
    assign ni.o_net_en       = net_en;
    assign ni.o_rx_pkt       = rx_pkt_q;
    assign ni.o_rx_val       = rx_full_q;
    assign ni.o_tx_count     = tx_count_q;
    assign ni.o_rx_count     = rx_count_q;
    assign ni.o_misroute     = misroute_q;

endmodule

// File: tb/tb_mesh_network_interface.sv
// Bench for mesh_network_interface at node (0,0) of a 4x4 mesh.
module tb_mesh_network_interface;
    import mesh_ni_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    mesh_network_interface_if #(.TS_WIDTH(16)) ni_if ();

    mesh_network_interface #(
        .X_NODES  (4),
        .Y_NODES  (4),
        .X_LOC    (0),
        .Y_LOC    (0),
        .TX_DEPTH (4),
        .TS_WIDTH (16)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .ni      (ni_if)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic packet_t mk(input logic [3:0] d, input logic [3:0] s,
                                   input logic [15:0] t, input logic [31:0] p);
        packet_t r;
        r.dest = d; r.source = s; r.timestamp = t; r.payload = p;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ni_if.i_pkt          = mk(4'h0, 4'h0, 16'h0, 32'h0);
        ni_if.i_pkt_val      = 1'b0;
        ni_if.i_net_en       = 1'b0;
        ni_if.i_net_data     = mk(4'h0, 4'h0, 16'h0, 32'h0);
        ni_if.i_net_data_val = 1'b0;
        ni_if.i_rx_en        = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pkt_en"},   64'(ni_if.o_pkt_en), 64'd1);
        chk({tag, "_net_val"},  64'(ni_if.o_net_data_val), 64'd0);
        chk({tag, "_net_data"}, 64'(ni_if.o_net_data), 64'd0);
        chk({tag, "_net_en"},   64'(ni_if.o_net_en), 64'd1);
        chk({tag, "_rx_val"},   64'(ni_if.o_rx_val), 64'd0);
        chk({tag, "_rx_pkt"},   64'(ni_if.o_rx_pkt), 64'd0);
        chk({tag, "_tx_cnt"},   64'(ni_if.o_tx_count), 64'd0);
        chk({tag, "_rx_cnt"},   64'(ni_if.o_rx_count), 64'd0);
        chk({tag, "_misroute"}, 64'(ni_if.o_misroute), 64'd0);
    endtask

    typedef struct {
        logic        pkt_val;
        logic [31:0] payload;
        logic        net_en;
        logic        e_pkt_en;
        logic        e_net_val;
        logic [31:0] e_payload;
        logic [15:0] e_ts;
        logic [31:0] e_tx_count;
    } vec_t;

    vec_t tbl[14];

    // Reference model state for the random phase.
    packet_t     q[$];
    logic        m_rx_full;
    packet_t     m_rx_pkt, p, exp_net;
    logic [31:0] m_txc, m_rxc;
    logic        m_mis;
    logic [15:0] m_ts, lat;
    logic [47:0] m_sum;
    logic [15:0] m_max;
    logic        do_pop, do_push, acc, drain;

    initial begin
        idle_inputs();
        reset_n = 1'b0;
        tick();
        do_reset();

        // Injection table: cycle c runs with ts == c.
        tbl[0]  = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 32'h0,  16'd0, 32'd0};
        tbl[1]  = '{1'b1, 32'hA1, 1'b1, 1'b1, 1'b0, 32'h0,  16'd0, 32'd0};
        tbl[2]  = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 32'hA1, 16'd1, 32'd0};
        tbl[3]  = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 32'h0,  16'd0, 32'd1};
        tbl[4]  = '{1'b1, 32'hB0, 1'b0, 1'b1, 1'b0, 32'h0,  16'd0, 32'd1};
        tbl[5]  = '{1'b1, 32'hB1, 1'b0, 1'b1, 1'b1, 32'hB0, 16'd4, 32'd1};
        tbl[6]  = '{1'b1, 32'hB2, 1'b0, 1'b1, 1'b1, 32'hB0, 16'd4, 32'd1};
        tbl[7]  = '{1'b1, 32'hB3, 1'b0, 1'b1, 1'b1, 32'hB0, 16'd4, 32'd1};
        tbl[8]  = '{1'b1, 32'hB4, 1'b0, 1'b0, 1'b1, 32'hB0, 16'd4, 32'd1};
        tbl[9]  = '{1'b0, 32'hB4, 1'b1, 1'b0, 1'b1, 32'hB0, 16'd4, 32'd1};
        tbl[10] = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 32'hB1, 16'd5, 32'd2};
        tbl[11] = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 32'hB2, 16'd6, 32'd3};
        tbl[12] = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 32'hB3, 16'd7, 32'd4};
        tbl[13] = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 32'h0,  16'd0, 32'd5};

        chk_reset_vals("rst0");
        for (int i = 0; i < 14; i++) begin
            // Core-supplied source/timestamp must be overwritten.
            ni_if.i_pkt     = mk(4'd5, 4'hF, 16'hDEAD, tbl[i].payload);
            ni_if.i_pkt_val = tbl[i].pkt_val;
            ni_if.i_net_en  = tbl[i].net_en;
            #1;
            chk($sformatf("tbl%0d_pkt_en", i), 64'(ni_if.o_pkt_en), 64'(tbl[i].e_pkt_en));
            chk($sformatf("tbl%0d_net_val", i), 64'(ni_if.o_net_data_val),
                64'(tbl[i].e_net_val));
            chk($sformatf("tbl%0d_net_data", i), 64'(ni_if.o_net_data),
                tbl[i].e_net_val ? 64'(mk(4'd5, 4'd0, tbl[i].e_ts, tbl[i].e_payload)) : 64'd0);
            chk($sformatf("tbl%0d_tx_cnt", i), 64'(ni_if.o_tx_count), 64'(tbl[i].e_tx_count));
            tick();
        end

        // Ejection: hold, drain+load, misroute.
        idle_inputs();
        ni_if.i_net_data_val = 1'b1;
        ni_if.i_net_data     = mk(4'd0, 4'd3, 16'h11, 32'hE1);
        #1;
        chk("ej_net_en_empty", 64'(ni_if.o_net_en), 64'd1);
        chk("ej_rx_val_empty", 64'(ni_if.o_rx_val), 64'd0);
        tick();
        ni_if.i_net_data = mk(4'd0, 4'd3, 16'h19, 32'hE9);
        #1;
        chk("ej_rx_val_full", 64'(ni_if.o_rx_val), 64'd1);
        chk("ej_net_en_full", 64'(ni_if.o_net_en), 64'd0);
        chk("ej_rx_pkt1", 64'(ni_if.o_rx_pkt), 64'(mk(4'd0, 4'd3, 16'h11, 32'hE1)));
        tick();
        ni_if.i_rx_en    = 1'b1;
        ni_if.i_net_data = mk(4'd0, 4'd7, 16'h22, 32'hE2);
        #1;
        chk("ej_blocked_kept", 64'(ni_if.o_rx_pkt), 64'(mk(4'd0, 4'd3, 16'h11, 32'hE1)));
        chk("ej_net_en_drain", 64'(ni_if.o_net_en), 64'd1);
        tick();
        chk("ej_rx_val_swap", 64'(ni_if.o_rx_val), 64'd1);
        chk("ej_rx_pkt2", 64'(ni_if.o_rx_pkt), 64'(mk(4'd0, 4'd7, 16'h22, 32'hE2)));
        chk("ej_rx_cnt1", 64'(ni_if.o_rx_count), 64'd1);
        ni_if.i_net_data = mk(4'd1, 4'd7, 16'h33, 32'hE3);
        tick();
        chk("mis_drain_rx_val", 64'(ni_if.o_rx_val), 64'd0);
        chk("mis_flag", 64'(ni_if.o_misroute), 64'd1);
        chk("mis_rx_cnt", 64'(ni_if.o_rx_count), 64'd2);
        ni_if.i_rx_en = 1'b0;
        tick();
        chk("mis2_rx_val", 64'(ni_if.o_rx_val), 64'd0);
        chk("mis2_rx_cnt", 64'(ni_if.o_rx_count), 64'd2);
        ni_if.i_net_data_val = 1'b0;
        tick();
        chk("mis_sticky", 64'(ni_if.o_misroute), 64'd1);

        // Reset mid-traffic: 3 queued packets and a full ejection register.
        ni_if.i_pkt          = mk(4'd9, 4'd0, 16'h0, 32'hC0);
        ni_if.i_pkt_val      = 1'b1;
        ni_if.i_net_data_val = 1'b1;
        ni_if.i_net_data     = mk(4'd0, 4'd2, 16'h44, 32'hD0);
        tick();
        ni_if.i_net_data_val = 1'b0;
        tick();
        tick();
        chk("pre_rst_net_val", 64'(ni_if.o_net_data_val), 64'd1);
        chk("pre_rst_rx_val", 64'(ni_if.o_rx_val), 64'd1);
        ni_if.i_net_data_val = 1'b1;
        reset_n = 1'b0;
        tick();
        chk_reset_vals("rst_mid");
        idle_inputs();
        reset_n = 1'b1;
        #1;
        chk_reset_vals("rst_after");

`ifdef MESH_NI_LATENCY_STATS_EN
        do_reset();
        ni_if.i_net_data_val = 1'b1;
        ni_if.i_net_data     = mk(4'd0, 4'd1, 16'hFFFE, 32'h1);
        ni_if.i_rx_en        = 1'b1;
        tick();
        idle_inputs();
        tick();
        tick();
        ni_if.i_rx_en = 1'b1;
        tick();
        chk("lat_sum_wrap", 64'(ni_if.o_lat_sum), 64'd5);
        chk("lat_max_wrap", 64'(ni_if.o_lat_max), 64'd5);
        ni_if.i_net_data_val = 1'b1;
        ni_if.i_net_data     = mk(4'd0, 4'd1, 16'd3, 32'h2);
        tick();
        ni_if.i_net_data_val = 1'b0;
        tick();
        chk("lat_sum_2", 64'(ni_if.o_lat_sum), 64'd7);
        chk("lat_max_2", 64'(ni_if.o_lat_max), 64'd5);
`endif

        // Random phase against a queue-level model.
        idle_inputs();
        do_reset();
        q.delete();
        m_rx_full = 1'b0; m_rx_pkt = '0; m_txc = '0; m_rxc = '0; m_mis = 1'b0;
        m_ts = '0; m_sum = '0; m_max = '0;
        for (int cyc = 0; cyc < 500; cyc++) begin
            ni_if.i_pkt_val = 1'($urandom_range(0, 1));
            ni_if.i_pkt = mk(4'($urandom), 4'($urandom), 16'($urandom), $urandom);
            ni_if.i_net_en = 1'($urandom_range(0, 2) == 0);
            ni_if.i_net_data_val = 1'($urandom_range(0, 1));
            ni_if.i_net_data = mk(($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0,
                                  4'($urandom), 16'($urandom), $urandom);
            ni_if.i_rx_en = 1'($urandom_range(0, 1));
            #1;
            exp_net = (q.size() != 0) ? q[0] : '0;
            chk("rnd_pkt_en", 64'(ni_if.o_pkt_en), 64'(q.size() < 4));
            chk("rnd_net_val", 64'(ni_if.o_net_data_val), 64'(q.size() != 0));
            chk("rnd_net_data", 64'(ni_if.o_net_data), 64'(exp_net));
            chk("rnd_net_en", 64'(ni_if.o_net_en), 64'(!m_rx_full || ni_if.i_rx_en));
            chk("rnd_rx_val", 64'(ni_if.o_rx_val), 64'(m_rx_full));
            chk("rnd_rx_pkt", 64'(ni_if.o_rx_pkt), 64'(m_rx_pkt));
            chk("rnd_tx_cnt", 64'(ni_if.o_tx_count), 64'(m_txc));
            chk("rnd_rx_cnt", 64'(ni_if.o_rx_count), 64'(m_rxc));
            chk("rnd_misroute", 64'(ni_if.o_misroute), 64'(m_mis));
`ifdef MESH_NI_LATENCY_STATS_EN
            chk("rnd_lat_sum", 64'(ni_if.o_lat_sum), 64'(m_sum));
            chk("rnd_lat_max", 64'(ni_if.o_lat_max), 64'(m_max));
`endif
            do_pop  = (q.size() != 0) && ni_if.i_net_en;
            do_push = ni_if.i_pkt_val && (q.size() < 4);
            if (do_pop) begin
                void'(q.pop_front());
                m_txc++;
            end
            if (do_push) begin
                p = ni_if.i_pkt;
                p.source = 4'd0;
                p.timestamp = m_ts;
                q.push_back(p);
            end
            acc   = ni_if.i_net_data_val && (!m_rx_full || ni_if.i_rx_en);
            drain = m_rx_full && ni_if.i_rx_en;
            if (drain) begin
                m_rxc++;
                lat = m_ts - m_rx_pkt.timestamp;
                m_sum = m_sum + 48'(lat);
                if (lat > m_max) m_max = lat;
                m_rx_full = 1'b0;
            end
            if (acc) begin
                if (ni_if.i_net_data.dest == 4'd0) begin
                    m_rx_full = 1'b1;
                    m_rx_pkt  = ni_if.i_net_data;
                end else begin
                    m_mis = 1'b1;
                end
            end
            m_ts++;
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mesh_network_interface.md
Name: mesh_network_interface

Overview:
- Core-side neighbour of the mesh router. Sits between a node's traffic source/sink and router port 0 (core).
- Injection path: accepts packets from the core, stamps them with source ID and injection time, buffers them in a TX FIFO, and presents them to router core input with val/en flow control.
- Ejection path: accepts packets from router core output, checks the destination, and hands them to the core sink through a one-entry output register.

Parameters:
- X_NODES, 4, mesh width.
- Y_NODES, 4, mesh height.
- X_LOC, 0, this node's X coordinate.
- Y_LOC, 0, this node's Y coordinate.
- TX_DEPTH, 4, injection FIFO depth in packets; power of 2, >=2.
- TS_WIDTH, 16, width of the free-running timestamp counter.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- i_pkt  in  packet_t  packet from core traffic source
- i_pkt_val  in  1  i_pkt valid
- o_pkt_en  out  1  NI can accept i_pkt this cycle
- o_net_data  out  packet_t  to router i_data[0]
- o_net_data_val  out  1  to router i_data_val[0]
- i_net_en  in  1  from router o_en[0]
- i_net_data  in  packet_t  from router o_data[0]
- i_net_data_val  in  1  from router o_data_val[0]
- o_net_en  out  1  to router i_en[0]
- o_rx_pkt  out  packet_t  ejected packet to core sink
- o_rx_val  out  1  o_rx_pkt valid
- i_rx_en  in  1  core sink ready
- o_tx_count  out  32  packets injected into router
- o_rx_count  out  32  packets delivered to core
- o_misroute  out  1  sticky: packet with wrong dest ejected

Behaviour:
- Handshake rule, all three interfaces: transfer occurs on a rising edge where val=1 and en=1. Val must not depend combinationally on en.
- NODE_ID = Y_LOC*X_NODES + X_LOC. Dest encoding is low half = X, high half = Y, each log2(X_NODES*Y_NODES)/2 bits.
- Timestamp: ts counter increments every cycle and wraps at 2^TS_WIDTH.
- Injection accept: o_pkt_en = !tx_full. When the FIFO is full and also popping in the same cycle, o_pkt_en stays 0 (no bypass).
- On accept, the FIFO stores i_pkt with source=NODE_ID and timestamp=ts (value before increment). The core-supplied source/timestamp fields are overwritten.
- TX output: o_net_data = FIFO head; o_net_data_val = !tx_empty.
  - Push-to-val latency is 1 cycle: an accept at edge N gives val high after edge N.
  - Pop when o_net_data_val && i_net_en.
  - Simultaneous push and pop keeps occupancy unchanged, including the full case when the pop frees space. Pointers wrap modulo TX_DEPTH.
- o_tx_count increments on each pop and saturates at 2^32-1.
- Ejection register (rx_full, rx_pkt):
  - o_net_en = !rx_full || i_rx_en.
  - On an i_net_data_val && o_net_en edge, the packet is checked.
    - dest == NODE_ID: it loads the register and rx_full is set.
    - dest != NODE_ID: it is consumed and dropped, o_misroute set (sticky until reset), and it is not counted.
  - Register output: o_rx_pkt = rx_pkt; o_rx_val = rx_full.
  - On o_rx_val && i_rx_en the entry is delivered and o_rx_count increments (saturating).
  - A simultaneous drain and load leaves rx_full=1 holding the new packet.
  - A drain plus a misrouted arrival clears rx_full.
- Reset (synchronous, any cycle including mid-transfer): FIFO emptied, pointers 0, ts=0, rx_full=0, counters 0, o_misroute=0. During reset and on the first cycle after: o_pkt_en=1, o_net_data_val=0, o_net_en=1, o_rx_val=0, o_net_data/o_rx_pkt=0. In-flight packets are discarded.

Optional Feature:
- MESH_NI_LATENCY_STATS_EN. When defined, adds outputs o_lat_sum (48 bits) and o_lat_max (TS_WIDTH bits).
- On each delivered packet, latency = (ts - o_rx_pkt.timestamp) mod 2^TS_WIDTH.
  - o_lat_sum accumulates latency (saturating); o_lat_max keeps the running maximum.
  - Both reset to 0.
- When not defined, neither port nor logic exists and behaviour is otherwise identical.

Decomposition:
- Shared package mesh_ni_pkg: NODE_ID computation function, dest X/Y slicing functions, TS_WIDTH default.
- packet_t comes from the existing shared config.
- One sub-module: mesh_ni_tx_fifo (parameterised packet FIFO with full/empty and simultaneous push/pop).
- Ejection register, checks and counters stay in the top level.

Test Plan:
- Reset, then push 1 packet (dest=5) at NODE_ID=0 with i_net_en=1 -> o_net_data_val=1 one cycle later; source=0, timestamp=1; o_tx_count=1 after the pop.
- i_net_en=0, push 5 packets, TX_DEPTH=4 -> 4 accepted, o_pkt_en=0 on the cycle after the 4th. Raise i_net_en -> packets leave in order A,B,C,D; o_pkt_en reasserts after the first pop.
- Ejection, i_rx_en=0: send dest=NODE_ID -> o_rx_val=1, o_net_en=0. Next cycle i_rx_en=1 with a new arrival -> both transfer, rx stays full with the 2nd packet; o_rx_count=1.
- Eject dest=NODE_ID+1 -> packet dropped, o_misroute=1 and stays 1; o_rx_count unchanged.
- Assert reset_n=0 for 1 cycle with 3 packets in the FIFO and rx_full=1 -> all outputs at reset values; o_tx_count=0.
- With MESH_NI_LATENCY_STATS_EN: deliver packets with timestamp 0xFFFE when ts=0x0003 -> latency 5 (wrap); then a latency of 2 -> o_lat_max=5, o_lat_sum=7.
